// File: rtl/regc_reader_if.sv
// regc_reader_if
//   Bundles the request side (rdReq/dataIn/rdAck) and the narrow CPU bus
//   side (busOut/busValid/busReady/busLast) of the C-register reader,
//   plus its status flags.
//   Modports:
//     master - the reader itself: drives the bus and status, receives
//              the request, the live register value and busReady.
//     slave  - the environment: issues requests, supplies dataIn,
//              back-pressures with busReady, clears overrun.
interface regc_reader_if #(
  parameter int DATA_W = 32,
  parameter int BUS_W  = 19
);
  logic              rdReq;
  logic [DATA_W-1:0] dataIn;
  logic              rdAck;
  logic [BUS_W-1:0]  busOut;
  logic              busValid;
  logic              busReady;
  logic              busLast;
  logic              busy;
  logic              overrun;
  logic              clrOverrun;

  modport master (
    input  rdReq, dataIn, busReady, clrOverrun,
    output rdAck, busOut, busValid, busLast, busy, overrun
  );

  modport slave (
    output rdReq, dataIn, busReady, clrOverrun,
    input  rdAck, busOut, busValid, busLast, busy, overrun
  );
endinterface

// File: rtl/regc_reader.sv
// regc_reader
//   Snapshots a DATA_W-bit holding register on request and streams the
//   snapshot over a BUS_W-bit valid/ready bus, low slice first, with the
//   top slice zero-extended. The register may change freely once the
//   snapshot is taken.
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - asynchronous active-low reset
//     io    - regc_reader_if.master: rdReq/dataIn/rdAck request side,
//             busOut/busValid/busReady/busLast bus side, busy, overrun
//             (sticky dropped-request flag) and clrOverrun.
//   All outputs are registered; there is no input-to-output path.
module regc_reader #(
  parameter int DATA_W = 32,
  parameter int BUS_W  = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  regc_reader_if.master  io
);

  localparam int BEATS = (DATA_W + BUS_W - 1) / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Beat slots rounded up to a power of two so any counter value indexes
  // a real slot; the extra slots read as zero.
  localparam int NSLOT = 1 << CNT_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [BUS_W-1:0]  bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_last_q, bus_last_d;
  logic              rd_ack_q, rd_ack_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic                   handshake;
  logic                   final_hs;
  logic [NSLOT*BUS_W-1:0] padded_d;
  logic [BUS_W-1:0]       beat_d [NSLOT];

  assign handshake = bus_valid_q & io.busReady;
  assign final_hs  = handshake & (cnt_q == LAST_BEAT);

  // Next snapshot zero-extended to a whole number of beats.
  always_comb begin
    padded_d = '0;
    padded_d[DATA_W-1:0] = snap_d;
  end

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_beat
    assign beat_d[gi] = padded_d[gi*BUS_W +: BUS_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    rd_ack_d  = 1'b0;
    // Set below takes priority over this clear.
    overrun_d = overrun_q & ~io.clrOverrun;

    unique case (state_q)
      IDLE: begin
        if (io.rdReq) begin
          snap_d   = io.dataIn;
          cnt_d    = '0;
          state_d  = SEND;
          rd_ack_d = 1'b1;
        end
      end
      SEND: begin
        if (final_hs) begin
          if (io.rdReq) begin
            // Chained read: reload without a bubble.
            snap_d   = io.dataIn;
            cnt_d    = '0;
            rd_ack_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (io.rdReq) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from next state so they appear registered with
    // one cycle of latency from the capturing edge.
    bus_valid_d = (state_d == SEND);
    busy_d      = bus_valid_d;
    bus_last_d  = bus_valid_d & (cnt_d == LAST_BEAT);
    bus_out_d   = bus_valid_d ? beat_d[cnt_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      snap_q      <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_last_q  <= 1'b0;
      rd_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_last_q  <= bus_last_d;
      rd_ack_q    <= rd_ack_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign io.busOut   = bus_out_q;
  assign io.busValid = bus_valid_q;
  assign io.busLast  = bus_last_q;
  assign io.rdAck    = rd_ack_q;
  assign io.busy     = busy_q;
  assign io.overrun  = overrun_q;

endmodule

// File: tb/tb_regc_reader.sv
// tb_regc_reader
//   Scoreboard bench for regc_reader: each accepted read pushes its two
//   expected beats {last, data}; a negedge monitor pops and compares on
//   every bus handshake. Directed checks cover ack timing, busy, stall
//   hold, chaining, overrun and asynchronous reset.
module tb_regc_reader;

  localparam int DATA_W = 32;
  localparam int BUS_W  = 19;

  logic clk;
  logic rst_n;

  regc_reader_if #(.DATA_W(DATA_W), .BUS_W(BUS_W)) io ();

  regc_reader #(.DATA_W(DATA_W), .BUS_W(BUS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [BUS_W:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected beats of one read: low 19 bits, then upper 13 bits zero-extended.
  task automatic push_read(input logic [31:0] d);
    logic [BUS_W-1:0] b0;
    logic [BUS_W-1:0] b1;
    b0 = d[18:0];
    b1 = {6'b0, d[31:19]};
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b1, b1});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: inputs change just after posedge, so at negedge
  // busReady/busValid show what the next rising edge will take.
  always @(negedge clk) begin
    if (rst_n && io.busValid && io.busReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {12'b0, io.busLast, io.busOut}, 32'hFFFF_FFFF);
      end else begin
        logic [BUS_W:0] e;
        e = exp_q.pop_front();
        check("beat_data", {13'b0, io.busOut}, {13'b0, e[BUS_W-1:0]});
        check("beat_last", {31'b0, io.busLast}, {31'b0, e[BUS_W]});
        $display("beat data=%h last=%0b", io.busOut, io.busLast);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    io.rdReq      = 1'b0;
    io.dataIn     = '0;
    io.busReady   = 1'b0;
    io.clrOverrun = 1'b0;
    repeat (3) step();
    check("rst_busOut", {13'b0, io.busOut}, 32'd0);
    check("rst_busValid", {31'b0, io.busValid}, 32'd0);
    check("rst_busLast", {31'b0, io.busLast}, 32'd0);
    check("rst_rdAck", {31'b0, io.rdAck}, 32'd0);
    check("rst_busy", {31'b0, io.busy}, 32'd0);
    check("rst_overrun", {31'b0, io.overrun}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single read, stall-free.
    io.dataIn = 32'hDEADBEEF; io.busReady = 1'b1; io.rdReq = 1'b1;
    push_read(32'hDEADBEEF);
    step();
    io.rdReq = 1'b0;
    check("t1_ack_n1", {31'b0, io.rdAck}, 32'd1);
    check("t1_valid_n1", {31'b0, io.busValid}, 32'd1);
    check("t1_beat0", {13'b0, io.busOut}, 32'h5BEEF);
    check("t1_last_n1", {31'b0, io.busLast}, 32'd0);
    step();
    check("t1_ack_n2", {31'b0, io.rdAck}, 32'd0);
    check("t1_beat1", {13'b0, io.busOut}, 32'h01BD5);
    check("t1_last_n2", {31'b0, io.busLast}, 32'd1);
    check("t1_busy_n2", {31'b0, io.busy}, 32'd1);
    step();
    check("t1_busy_n3", {31'b0, io.busy}, 32'd0);
    check("t1_valid_n3", {31'b0, io.busValid}, 32'd0);

    // Stall with dataIn changing under the snapshot.
    io.busReady = 1'b0; io.dataIn = 32'hFFFFFFFF; io.rdReq = 1'b1;
    push_read(32'hFFFFFFFF);
    step();
    io.rdReq = 1'b0; io.dataIn = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_data", {13'b0, io.busOut}, 32'h7FFFF);
      check("t2_hold_last", {31'b0, io.busLast}, 32'd0);
      if (i < 2) step();
    end
    io.busReady = 1'b1;
    step();
    check("t2_beat1", {13'b0, io.busOut}, 32'h01FFF);
    check("t2_last", {31'b0, io.busLast}, 32'd1);
    step();
    check("t2_idle", {31'b0, io.busValid}, 32'd0);

    // Back-to-back: new request on the final-beat handshake cycle.
    io.dataIn = 32'hDEADBEEF; io.rdReq = 1'b1;
    push_read(32'hDEADBEEF);
    step();
    io.rdReq = 1'b0;
    step();
    check("t3_last_before", {31'b0, io.busLast}, 32'd1);
    io.dataIn = 32'h00000001; io.rdReq = 1'b1;
    push_read(32'h00000001);
    step();
    io.rdReq = 1'b0;
    check("t3_valid_chain", {31'b0, io.busValid}, 32'd1);
    check("t3_ack_chain", {31'b0, io.rdAck}, 32'd1);
    check("t3_beat0", {13'b0, io.busOut}, 32'h00001);
    step();
    check("t3_valid_b1", {31'b0, io.busValid}, 32'd1);
    check("t3_beat1", {13'b0, io.busOut}, 32'h00000);
    check("t3_overrun", {31'b0, io.overrun}, 32'd0);
    step();
    check("t3_idle", {31'b0, io.busy}, 32'd0);

    // Overrun during beat0 stall.
    io.busReady = 1'b0; io.dataIn = 32'h12345678; io.rdReq = 1'b1;
    push_read(32'h12345678);
    step();
    io.dataIn = 32'hAAAAAAAA;
    step();
    io.rdReq = 1'b0;
    check("t4_overrun_set", {31'b0, io.overrun}, 32'd1);
    check("t4_no_ack", {31'b0, io.rdAck}, 32'd0);
    check("t4_beat0_kept", {13'b0, io.busOut}, 32'h45678);
    io.busReady = 1'b1;
    step();
    check("t4_beat1", {13'b0, io.busOut}, 32'h00246);
    step();
    check("t4_idle", {31'b0, io.busValid}, 32'd0);
    check("t4_sticky", {31'b0, io.overrun}, 32'd1);
    // Clear and new overrun in the same cycle: set wins.
    io.busReady = 1'b0; io.dataIn = 32'h0F0F0F0F; io.rdReq = 1'b1;
    push_read(32'h0F0F0F0F);
    step();
    io.clrOverrun = 1'b1;
    step();
    io.rdReq = 1'b0; io.clrOverrun = 1'b0;
    check("t4_set_wins", {31'b0, io.overrun}, 32'd1);
    io.clrOverrun = 1'b1;
    step();
    io.clrOverrun = 1'b0;
    check("t4_cleared", {31'b0, io.overrun}, 32'd0);
    io.busReady = 1'b1;
    repeat (3) step();
    check("t4_done", {31'b0, io.busy}, 32'd0);

    // Asynchronous reset during beat1 stall.
    io.busReady = 1'b0; io.dataIn = 32'h87654321; io.rdReq = 1'b1;
    push_read(32'h87654321);
    step();
    io.rdReq = 1'b0; io.busReady = 1'b1;
    step();
    io.busReady = 1'b0;
    check("t5_in_beat1", {31'b0, io.busLast}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busOut", {13'b0, io.busOut}, 32'd0);
    check("t5_rst_valid", {31'b0, io.busValid}, 32'd0);
    check("t5_rst_last", {31'b0, io.busLast}, 32'd0);
    check("t5_rst_busy", {31'b0, io.busy}, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1; io.busReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_replay", {31'b0, io.busValid}, 32'd0);
    end

    // Recovery read after reset.
    io.dataIn = 32'hCAFEF00D; io.rdReq = 1'b1;
    push_read(32'hCAFEF00D);
    step();
    io.rdReq = 1'b0;
    check("t6_ack", {31'b0, io.rdAck}, 32'd1);
    repeat (3) step();

    check("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
